// File: rtl/conv12_out_reader_pkg.sv
// rtl/conv12_out_reader_pkg.sv - shared geometry, state encoding and pixel index helper for the conv12 result reader
package conv12_out_reader_pkg;

  localparam int OUT_DIM = 10;
  localparam int PIX_W   = 2;
  localparam int NPIX    = OUT_DIM * OUT_DIM;
  localparam int FRAME_W = NPIX * PIX_W;

  localparam logic [3:0] LAST_IDX = 4'(OUT_DIM - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Bit offset of pixel (row, col) inside the flattened frame; 8 bits covers 99*PIX_W.
  function automatic logic [7:0] pix_offset(input logic [3:0] row, input logic [3:0] col);
    logic [7:0] idx;
    idx = 8'(row) * 8'(OUT_DIM) + 8'(col);
    return idx * 8'(PIX_W);
  endfunction

endpackage

// File: rtl/conv12_out_reader_rc_counter.sv
// rtl/conv12_out_reader_rc_counter.sv - row-major row/col counter with wrap and end-of-line/frame flags
module conv12_out_reader_rc_counter
  import conv12_out_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] row_next,
  output logic [3:0] col_next,
  output logic       eol,
  output logic       eof
);

  // Next position: clear wins, otherwise advance column and wrap into the next row.
  // After the last pixel both counters wrap to zero so they never exceed OUT_DIM-1.
  always_comb begin
    row_next = row;
    col_next = col;
    if (clear) begin
      row_next = 4'd0;
      col_next = 4'd0;
    end else if (en) begin
      if (col == LAST_IDX) begin
        col_next = 4'd0;
        row_next = (row == LAST_IDX) ? 4'd0 : row + 4'd1;
      end else begin
        col_next = col + 4'd1;
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= 4'd0;
      col <= 4'd0;
    end else begin
      row <= row_next;
      col <= col_next;
    end
  end

  assign eol = (col == LAST_IDX);
  assign eof = eol && (row == LAST_IDX);

endmodule

// File: rtl/conv12_out_reader.sv
// rtl/conv12_out_reader.sv - captures one conv12 result frame and streams it out one pixel per beat
module conv12_out_reader
  import conv12_out_reader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               frame_ready,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic [3:0]         pix_row,
  output logic [3:0]         pix_col,
  output logic               pix_eol,
  output logic               pix_eof,
  output logic               overrun
);

  state_t             state;
  state_t             state_next;
  logic [FRAME_W-1:0] shadow;
  logic               accept;
  logic               xfer;
  logic [3:0]         row_next;
  logic [3:0]         col_next;
  logic [7:0]         bit_off;

  conv12_out_reader_rc_counter u_rc (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (xfer),
    .row      (pix_row),
    .col      (pix_col),
    .row_next (row_next),
    .col_next (col_next),
    .eol      (pix_eol),
    .eof      (pix_eof)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs; frame_ready stays low while reset is held.
  always_comb begin
    state_next  = state;
    frame_ready = 1'b0;
    pix_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        frame_ready = !rst;
        if (frame_valid && !rst) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        pix_valid = 1'b1;
        if (pix_ready && pix_eof) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept  = frame_ready & frame_valid;
  assign xfer    = pix_valid & pix_ready;
  assign bit_off = pix_offset(row_next, col_next);

  // Shadow capture and registered pixel fetch; pixel 0 comes straight from the
  // accepted frame because the shadow only holds it from the next cycle on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      pix_data <= '0;
    end else if (accept) begin
      shadow   <= frame_data;
      pix_data <= frame_data[PIX_W-1:0];
    end else if (xfer) begin
      pix_data <= shadow[bit_off +: PIX_W];
    end
  end

  // Overrun pulse: a frame offered while streaming is dropped and flagged next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= frame_valid && (state == ST_STREAM);
  end

endmodule
